// File: rtl/nar_fx_pkg.sv
// Shared fixed-point helpers for the NAR-Net datapath: FSM state encoding,
// a width-generic saturating clamp, and rail constants for the default
// configuration (N=10, G=4).
package nar_fx_pkg;

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  // Clamp result: value is sign-extended to 32 bits, sat flags a clamp.
  typedef struct packed {
    logic [31:0] value;
    logic        sat;
  } clamp_t;

  localparam int unsigned NarN   = 10;
  localparam int unsigned NarG   = 4;
  localparam int signed   ResMax = (1 <<< (NarN - 1)) - 1;
  localparam int signed   ResMin = -(1 <<< (NarN - 1));
  localparam int signed   AccMax = (1 <<< (NarN + NarG - 1)) - 1;
  localparam int signed   AccMin = -(1 <<< (NarN + NarG - 1));

  // Interpret the low from_w bits of value as signed, clamp to a to_w-bit range.
  function automatic clamp_t sat_clamp(input logic [31:0] value,
                                       input int unsigned from_w,
                                       input int unsigned to_w);
    longint signed v, hi, lo;
    clamp_t res;
    v  = longint'(signed'(value));
    v  = (v <<< (64 - from_w)) >>> (64 - from_w);
    hi = (longint'(1) <<< (to_w - 1)) - longint'(1);
    lo = -(longint'(1) <<< (to_w - 1));
    if (v > hi) begin
      res.value = hi[31:0];
      res.sat   = 1'b1;
    end else if (v < lo) begin
      res.value = lo[31:0];
      res.sat   = 1'b1;
    end else begin
      res.value = v[31:0];
      res.sat   = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/sat_adder.sv
// W-bit two's-complement adder that saturates at the rails instead of wrapping.
module sat_adder #(
  parameter int unsigned W = 14
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W:0] raw;

  // One extra bit exposes overflow; sign of raw picks the rail.
  always_comb begin
    raw = {a[W-1], a} + {b[W-1], b};
    ovf = raw[W] ^ raw[W-1];
    if (ovf) begin
      sum = raw[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      sum = raw[W-1:0];
    end
  end

endmodule

// File: rtl/seq_accumulator.sv
// Saturating sequence accumulator: sums len signed Q-format terms with G guard
// bits and returns one clamped N-bit result with a sticky saturation flag.
// Optional SEQ_ACC_BIAS_EN adds a bias port that seeds the accumulator.
module seq_accumulator
  import nar_fx_pkg::*;
#(
  parameter int unsigned N  = 10,
  parameter int unsigned Q  = 9,
  parameter int unsigned G  = 4,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] len,
`ifdef SEQ_ACC_BIAS_EN
  input  logic [N-1:0]  bias,
`endif
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          out_sat,
  output logic          busy
);

  localparam int unsigned AW = N + G;
  // Input and output share the Q format, so Q needs no realignment logic.
  localparam logic QOk = (Q < N);

  state_t        state;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic [CW-1:0] len_q;
  logic          sticky;

  logic [AW-1:0] init_acc;
  logic [AW-1:0] term_ext;
  logic [AW-1:0] add_sum;
  logic          add_ovf;
  clamp_t        beat_cl;
  clamp_t        init_cl;
  logic          unused_bits;

`ifdef SEQ_ACC_BIAS_EN
  assign init_acc = {{G{bias[N-1]}}, bias};
`else
  assign init_acc = '0;
`endif

  assign term_ext = {{G{in_data[N-1]}}, in_data};

  sat_adder #(
    .W(AW)
  ) u_sat_adder (
    .a  (acc),
    .b  (term_ext),
    .sum(add_sum),
    .ovf(add_ovf)
  );

  // Output clamps for the two ways into OUT: last beat, or an empty run.
  always_comb begin
    beat_cl = sat_clamp(32'(signed'(add_sum)), AW, N);
    init_cl = sat_clamp(32'(signed'(init_acc)), AW, N);
  end

  assign unused_bits = ^{beat_cl.value[31:N], init_cl.value[31:N], QOk};

  // Handshake outputs decode straight from state.
  assign busy      = (state != IDLE);
  assign in_ready  = (state == ACC);
  assign out_valid = (state == OUT);

  // Run FSM, accumulator, beat counter and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      len_q    <= '0;
      sticky   <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            len_q  <= len;
            acc    <= init_acc;
            cnt    <= '0;
            sticky <= 1'b0;
            if (len == '0) begin
              state    <= OUT;
              out_data <= init_cl.value[N-1:0];
              out_sat  <= init_cl.sat;
            end else begin
              state <= ACC;
            end
          end
        end
        ACC: begin
          if (in_valid) begin
            acc    <= add_sum;
            cnt    <= cnt + CW'(1);
            sticky <= sticky | add_ovf;
            if (cnt == len_q - CW'(1)) begin
              state    <= OUT;
              out_data <= beat_cl.value[N-1:0];
              out_sat  <= beat_cl.sat | sticky | add_ovf;
            end
          end
        end
        OUT: begin
          // A start in this cycle is dropped; only the handshake matters.
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
